// File: rtl/ppu_tile_render_fsm_n.sv
// rtl/ppu_tile_render_fsm_n.sv - PPU tile-row renderer: VRAM fetch, sprite/BG composition, VGA writes
module ppu_tile_render_fsm_n #(
    parameter int NUM_SPRITES = 8,
    parameter int VRAM_AW     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [8:0]               curr_row,
    input  logic [8:0]               curr_col,
    output logic [VRAM_AW-1:0]       vram_addr,
    input  logic [7:0]               vram_data_in,
    input  logic [7:0]               ppu_ctrl1,
    input  logic [7:0]               ppu_ctrl2,
    input  logic [127:0]             bacground_colors,
    input  logic [15:0]              background_pattern_base,
    input  logic [15:0]              nametable_ptr,
    input  logic [2:0]               pattern_table_offset,
    input  logic [15:0]              attr_ptr,
    input  logic [1:0]               attr_shift,
    input  logic [127:0]             sprite_colors,
    input  logic [15:0]              sprite_pattern_base,
    input  logic [NUM_SPRITES-1:0]   sprite_on_tile,
    input  logic [8*NUM_SPRITES-1:0] sprite_tile_num,
    input  logic [8*NUM_SPRITES-1:0] sprite_row,
    input  logic [8*NUM_SPRITES-1:0] sprite_col,
    input  logic [8*NUM_SPRITES-1:0] sprite_attr,
    output logic [8:0]               vga_ram_row,
    output logic [8:0]               vga_ram_col,
    output logic [7:0]               vga_ram_data,
    output logic                     vga_write_en,
    output logic                     busy,
    output logic [NUM_SPRITES-1:0]   sprite_hit
);
    localparam int SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_NT_A, S_NT_D, S_AT_A, S_AT_D, S_BL_A, S_BL_D, S_BH_A, S_BH_D,
        S_SL_A, S_SL_D, S_SH_A, S_SH_D, S_WR
    } state_t;

    state_t r_state, w_next;

    // Segment parameters frozen at start
    logic [8:0]               r_row, r_col;
    logic                     r_tall, r_bg_en, r_spr_en;
    logic [127:0]             r_bg_colors, r_spr_colors;
    logic [15:0]              r_bg_base, r_nt_ptr, r_attr_ptr, r_spr_base;
    logic [2:0]               r_pt_off;
    logic [1:0]               r_attr_shift;
    logic [NUM_SPRITES-1:0]   r_spr_on;
    logic [8*NUM_SPRITES-1:0] r_spr_tile, r_spr_row, r_spr_col, r_spr_attr;

    // Fetched bytes and sequencing
    logic [7:0]               r_nt, r_at, r_bg_lo, r_bg_hi;
    logic [8*NUM_SPRITES-1:0] r_sp_lo, r_sp_hi;
    logic [SW-1:0]            r_spr;
    logic [2:0]               r_pix;
    logic [NUM_SPRITES-1:0]   r_hit;

    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{ppu_ctrl1[7:6], ppu_ctrl1[4:0], ppu_ctrl2[7:5], ppu_ctrl2[2:0]};

    logic w_last_spr;
    assign w_last_spr = (r_spr == SW'(NUM_SPRITES - 1));

    // Address of the current sprite slot's low pattern byte
    logic [7:0]  w_s_tile, w_s_row, w_s_attr, w_s_tile2;
    logic [8:0]  w_s_dy;
    logic [3:0]  w_s_dyv;
    logic [15:0] w_sp_addr, w_bg_lo_addr;
    logic [8:0]  w_h;

    assign w_h          = r_tall ? 9'd16 : 9'd8;
    assign w_s_tile     = r_spr_tile[8*r_spr +: 8];
    assign w_s_row      = r_spr_row[8*r_spr +: 8];
    assign w_s_attr     = r_spr_attr[8*r_spr +: 8];
    assign w_s_dy       = r_row - {1'b0, w_s_row};
    assign w_s_dyv      = w_s_attr[7] ? (w_h[3:0] - 4'd1 - w_s_dy[3:0]) : w_s_dy[3:0];
    assign w_s_tile2    = {w_s_tile[7:1], 1'b0} + {7'd0, w_s_dyv[3]};
    assign w_sp_addr    = r_tall ? ((w_s_tile[0] ? 16'h1000 : 16'h0000) + {4'd0, w_s_tile2, 4'd0}
                                    + {13'd0, w_s_dyv[2:0]})
                                 : (r_spr_base + {4'd0, w_s_tile, 4'd0} + {13'd0, w_s_dyv[2:0]});
    assign w_bg_lo_addr = r_bg_base + {4'd0, r_nt, 4'd0} + {13'd0, r_pt_off};

    // Pixel composition for the current WR cycle
    logic [9:0] w_x;
    logic       w_on;
    logic [2:0] w_bg_bit;
    logic [1:0] w_bg_val, w_pal;
    logic       w_bg_opq;
    logic [7:0] w_bg_color;

    assign w_x        = {r_col[8], r_col} + {7'd0, r_pix};
    assign w_on       = (w_x[9:8] == 2'b00);
    assign w_bg_bit   = 3'd7 - r_pix;
    assign w_bg_val   = r_bg_en ? {r_bg_hi[w_bg_bit], r_bg_lo[w_bg_bit]} : 2'b00;
    assign w_bg_opq   = (w_bg_val != 2'b00);
    assign w_pal      = r_at[{r_attr_shift, 1'b0} +: 2];
    assign w_bg_color = r_bg_colors[{w_pal, w_bg_val, 3'b000} +: 8];

    logic [NUM_SPRITES-1:0]   w_opq, w_hit_set;
    logic [2*NUM_SPRITES-1:0] w_vals;

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
        logic [8:0] w_dy;
        logic [9:0] w_dx_full;
        logic [2:0] w_dx, w_bit;
        logic [7:0] w_lo, w_hi;
        logic [1:0] w_val;
        assign w_dy          = r_row - {1'b0, r_spr_row[8*gi +: 8]};
        assign w_dx_full     = w_x - {2'b00, r_spr_col[8*gi +: 8]};
        assign w_dx          = r_spr_attr[8*gi + 6] ? ~w_dx_full[2:0] : w_dx_full[2:0];
        assign w_bit         = 3'd7 - w_dx;
        assign w_lo          = r_sp_lo[8*gi +: 8];
        assign w_hi          = r_sp_hi[8*gi +: 8];
        assign w_val         = {w_hi[w_bit], w_lo[w_bit]};
        assign w_opq[gi]     = r_spr_on[gi] & r_spr_en & (w_dy < w_h)
                               & (w_dx_full[9:3] == 7'd0) & (w_val != 2'b00);
        assign w_vals[2*gi +: 2] = w_val;
        assign w_hit_set[gi] = w_opq[gi] & w_bg_opq & w_on;
    end

    // Lowest-index opaque sprite wins, then priority against the background
    logic       w_win;
    logic [1:0] w_win_val;
    logic [7:0] w_win_attr, w_pix_color;
    always_comb begin
        w_win      = 1'b0;
        w_win_val  = 2'b00;
        w_win_attr = 8'h00;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opq[i]) begin
                w_win      = 1'b1;
                w_win_val  = w_vals[2*i +: 2];
                w_win_attr = r_spr_attr[8*i +: 8];
            end
        end
        if (w_win && (!w_win_attr[5] || !w_bg_opq))
            w_pix_color = r_spr_colors[{w_win_attr[1:0], w_win_val, 3'b000} +: 8];
        else if (w_bg_opq)
            w_pix_color = w_bg_color;
        else
            w_pix_color = r_bg_colors[7:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state sequencing: fixed fetch order, then eight write cycles
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_NT_A;
            S_NT_A:  w_next = S_NT_D;
            S_NT_D:  w_next = S_AT_A;
            S_AT_A:  w_next = S_AT_D;
            S_AT_D:  w_next = S_BL_A;
            S_BL_A:  w_next = S_BL_D;
            S_BL_D:  w_next = S_BH_A;
            S_BH_A:  w_next = S_BH_D;
            S_BH_D:  w_next = S_SL_A;
            S_SL_A:  w_next = S_SL_D;
            S_SL_D:  w_next = S_SH_A;
            S_SH_A:  w_next = S_SH_D;
            S_SH_D:  w_next = w_last_spr ? S_WR : S_SL_A;
            S_WR:    if (r_pix == 3'd7) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    logic [15:0] w_addr16;
    always_comb begin
        case (r_state)
            S_NT_A:  w_addr16 = r_nt_ptr;
            S_AT_A:  w_addr16 = r_attr_ptr;
            S_BL_A:  w_addr16 = w_bg_lo_addr;
            S_BH_A:  w_addr16 = w_bg_lo_addr + 16'd8;
            S_SL_A:  w_addr16 = w_sp_addr;
            S_SH_A:  w_addr16 = w_sp_addr + 16'd8;
            default: w_addr16 = 16'h0000;
        endcase
        vram_addr    = VRAM_AW'(w_addr16);
        busy         = (r_state != S_IDLE);
        vga_write_en = (r_state == S_WR) && w_on;
        vga_ram_row  = (r_state == S_WR) ? r_row : 9'd0;
        vga_ram_col  = (r_state == S_WR) ? w_x[8:0] : 9'd0;
        vga_ram_data = (r_state == S_WR) ? w_pix_color : 8'h00;
    end

    assign sprite_hit = r_hit;

    // Input capture, VRAM byte capture, counters and sticky hit flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0; r_col <= '0; r_tall <= 1'b0; r_bg_en <= 1'b0; r_spr_en <= 1'b0;
            r_bg_colors <= '0; r_spr_colors <= '0; r_bg_base <= '0; r_nt_ptr <= '0;
            r_attr_ptr <= '0; r_spr_base <= '0; r_pt_off <= '0; r_attr_shift <= '0;
            r_spr_on <= '0; r_spr_tile <= '0; r_spr_row <= '0; r_spr_col <= '0; r_spr_attr <= '0;
            r_nt <= '0; r_at <= '0; r_bg_lo <= '0; r_bg_hi <= '0; r_sp_lo <= '0; r_sp_hi <= '0;
            r_spr <= '0; r_pix <= '0; r_hit <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_row        <= curr_row;
                    r_col        <= curr_col;
                    r_tall       <= ppu_ctrl1[5];
                    r_bg_en      <= ppu_ctrl2[3];
                    r_spr_en     <= ppu_ctrl2[4];
                    r_bg_colors  <= bacground_colors;
                    r_spr_colors <= sprite_colors;
                    r_bg_base    <= background_pattern_base;
                    r_nt_ptr     <= nametable_ptr;
                    r_attr_ptr   <= attr_ptr;
                    r_spr_base   <= sprite_pattern_base;
                    r_pt_off     <= pattern_table_offset;
                    r_attr_shift <= attr_shift;
                    r_spr_on     <= sprite_on_tile;
                    r_spr_tile   <= sprite_tile_num;
                    r_spr_row    <= sprite_row;
                    r_spr_col    <= sprite_col;
                    r_spr_attr   <= sprite_attr;
                    r_spr        <= '0;
                    r_pix        <= '0;
                    r_hit        <= '0;
                end
                S_NT_D: r_nt    <= vram_data_in;
                S_AT_D: r_at    <= vram_data_in;
                S_BL_D: r_bg_lo <= vram_data_in;
                S_BH_D: r_bg_hi <= vram_data_in;
                S_SL_D: r_sp_lo[8*r_spr +: 8] <= vram_data_in;
                S_SH_D: begin
                    r_sp_hi[8*r_spr +: 8] <= vram_data_in;
                    if (!w_last_spr) r_spr <= r_spr + 1'b1;
                end
                S_WR: begin
                    r_pix <= r_pix + 3'd1;
                    r_hit <= r_hit | w_hit_set;
                end
                default: ;
            endcase
        end
    end
endmodule
